// File: rtl/seq_detector_param.sv
// seq_detector_param: parameterised serial pattern detector.
// It matches an arbitrary-length pattern (MSB first) on a qualified 1-bit
// stream. It supports Mealy or Moore detect timing, overlapping or
// non-overlapping matches, and a saturating match counter.
// Optional feature macro: SEQDET_PROG_EN. It adds a runtime-loadable pattern
// through the pat_load/pat_data ports.
//
// Handshake: there is no back-pressure. A bit is consumed on every rising edge
// where in_valid=1 and neither clear nor pat_load is asserted. Bits presented
// with in_valid=0 are ignored and leave all state untouched.
//
// The fill counter is the FSM. state mirrors it as EMPTY/FILLING/ARMED so that
// checkers can bind to a readable encoding.
module seq_detector_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MEALY   = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         clear,
`ifdef SEQDET_PROG_EN
    input  logic                         pat_load,
    input  logic [SEQ_LEN-1:0]           pat_data,
`endif
    output logic                         detect,
    output logic [CNT_W-1:0]             match_count,
    output logic                         count_sat,
    output logic [$clog2(SEQ_LEN+1)-1:0] fill,
    output logic [1:0]                   state
);

    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);
    localparam logic [FW-1:0] PRE  = FW'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    logic [SEQ_LEN-2:0] history;
    logic [SEQ_LEN-1:0] pattern;
    logic [FW-1:0]      fill_q;
    logic [FW-1:0]      fill_next;
    state_t             state_q;
    state_t             state_next;
    logic [CNT_W-1:0]   count_q;
    logic               detect_q;
    logic               load;
    logic               hit;

`ifdef SEQDET_PROG_EN
    assign load = pat_load;

    // Runtime pattern register, reloaded whenever pat_load is pulsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= SEQ;
        end else if (pat_load) begin
            pattern <= pat_data;
        end
    end
`else
    assign load    = 1'b0;
    assign pattern = SEQ;
`endif

    // A match uses the SEQ_LEN-1 stored bits plus the bit arriving now.
    // Clear and pattern load both discard the incoming bit.
    assign hit = in_valid & ~clear & ~load & (fill_q >= PRE) &
                 ({history, in_bit} == pattern);

    // Next fill count and the state that this fill count represents.
    always_comb begin
        fill_next = fill_q;
        if (clear || load) begin
            fill_next = '0;
        end else if (in_valid) begin
            if (hit && !OVERLAP) begin
                fill_next = '0;
            end else if (fill_q != FULL) begin
                fill_next = fill_q + FW'(1);
            end
        end
        state_next = FILLING;
        if (fill_next == '0) begin
            state_next = EMPTY;
        end else if (fill_next == FULL) begin
            state_next = ARMED;
        end
    end

    // History shift, fill/state, match counter and registered detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history  <= '0;
            fill_q   <= '0;
            state_q  <= EMPTY;
            count_q  <= '0;
            detect_q <= 1'b0;
        end else begin
            fill_q   <= fill_next;
            state_q  <= state_next;
            detect_q <= hit;
            if (in_valid && !clear && !load) begin
                history <= (SEQ_LEN-1)'({history, in_bit});
            end
            if (clear) begin
                count_q <= '0;
            end else if (hit && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign detect      = MEALY ? (hit & ~reset) : detect_q;
    assign match_count = count_q;
    assign count_sat   = &count_q;
    assign fill        = fill_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed bench for seq_detector_param.
// It covers four instances: default, non-overlapping, Mealy, and a 2-bit
// saturating counter with an all-ones pattern.
module tb_seq_detector_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic vld_a = 1'b0, bit_a = 1'b0, clr_a = 1'b0;
    logic vld_m = 1'b0, bit_m = 1'b0, clr_m = 1'b0;
    logic vld_s = 1'b0, bit_s = 1'b0, clr_s = 1'b0;
`ifdef SEQDET_PROG_EN
    logic       pl_a = 1'b0;
    logic [3:0] pd_a = 4'b0000;
    logic       pl_off = 1'b0;
    logic [3:0] pd_off = 4'b0000;
`endif

    logic       det_d, det_n, det_m, det_s;
    logic [7:0] cnt_d, cnt_n, cnt_m;
    logic [1:0] cnt_s;
    logic       sat_d, sat_n, sat_m, sat_s;
    logic [2:0] fill_d, fill_n, fill_m, fill_s;
    logic [1:0] st_d, st_n, st_m, st_s;

    // ---------------- DUTs ----------------
    seq_detector_param u_def (
        .clk(clk), .reset(reset), .in_valid(vld_a), .in_bit(bit_a), .clear(clr_a),
`ifdef SEQDET_PROG_EN
        .pat_load(pl_a), .pat_data(pd_a),
`endif
        .detect(det_d), .match_count(cnt_d), .count_sat(sat_d), .fill(fill_d), .state(st_d)
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .in_valid(vld_a), .in_bit(bit_a), .clear(clr_a),
`ifdef SEQDET_PROG_EN
        .pat_load(pl_off), .pat_data(pd_off),
`endif
        .detect(det_n), .match_count(cnt_n), .count_sat(sat_n), .fill(fill_n), .state(st_n)
    );

    seq_detector_param #(.MEALY(1'b1)) u_mealy (
        .clk(clk), .reset(reset), .in_valid(vld_m), .in_bit(bit_m), .clear(clr_m),
`ifdef SEQDET_PROG_EN
        .pat_load(pl_off), .pat_data(pd_off),
`endif
        .detect(det_m), .match_count(cnt_m), .count_sat(sat_m), .fill(fill_m), .state(st_m)
    );

    seq_detector_param #(.SEQ(4'b1111), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(vld_s), .in_bit(bit_s), .clear(clr_s),
`ifdef SEQDET_PROG_EN
        .pat_load(pl_off), .pat_data(pd_off),
`endif
        .detect(det_s), .match_count(cnt_s), .count_sat(sat_s), .fill(fill_s), .state(st_s)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait for the next active edge and step just past it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One table row: inputs shared by u_def/u_nov plus expected values.
    // The expected values are observed at the negedge of that cycle.
    typedef struct {
        logic v;
        logic b;
        logic c;
        logic det;
        int   fill;
        int   cnt;
        int   st;
        logic ndet;
        int   nfill;
        int   ncnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // stream 1011011, two idles, clear (with a discarded valid bit), idle
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1, 1'b0, 2, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 1, 1'b0, 3, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 2, 1'b1, 0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 2, 1'b0, 1, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 2, 1'b0, 2, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 2, 2, 1'b0, 3, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 2, 2, 1'b0, 3, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 2, 2, 1'b0, 3, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0};

        // ---- reset state ----
        #2;
        chk("rst det", det_d, 0);
        chk("rst fill", fill_d, 0);
        chk("rst cnt", cnt_d, 0);
        chk("rst sat", sat_s, 0);
        chk("rst state", st_d, 0);
        chk("rst mealy det", det_m, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // ---- table: default and non-overlap instances ----
        for (int i = 0; i < 11; i++) begin
            vld_a = tbl[i].v;
            bit_a = tbl[i].b;
            clr_a = tbl[i].c;
            @(negedge clk);
            chk($sformatf("t%0d det", i), det_d, tbl[i].det);
            chk($sformatf("t%0d fill", i), fill_d, tbl[i].fill);
            chk($sformatf("t%0d cnt", i), cnt_d, tbl[i].cnt);
            chk($sformatf("t%0d state", i), st_d, tbl[i].st);
            chk($sformatf("t%0d nov det", i), det_n, tbl[i].ndet);
            chk($sformatf("t%0d nov fill", i), fill_n, tbl[i].nfill);
            chk($sformatf("t%0d nov cnt", i), cnt_n, tbl[i].ncnt);
            next_cycle();
        end
        vld_a = 1'b0;
        clr_a = 1'b0;

        // ---- Mealy with a 3-cycle gap between bits 2 and 3 ----
        begin
            logic mv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            logic mb[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            int   mf[8] = '{0, 1, 2, 2, 2, 2, 3, 4};
            logic md[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 8; i++) begin
                vld_m = mv[i];
                bit_m = mb[i];
                @(negedge clk);
                chk($sformatf("mealy%0d det", i), det_m, md[i]);
                chk($sformatf("mealy%0d fill", i), fill_m, mf[i]);
                next_cycle();
            end
            chk("mealy cnt", cnt_m, 1);
            vld_m = 1'b0;
        end

        // ---- saturation: 8 ones, idle, clear, idle ----
        for (int k = 0; k < 11; k++) begin
            int exp_cnt;
            vld_s = (k < 8);
            bit_s = (k < 8);
            clr_s = (k == 9);
            exp_cnt = (k <= 3) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
            if (k == 10) exp_cnt = 0;
            @(negedge clk);
            chk($sformatf("sat%0d det", k), det_s, (k >= 4 && k <= 8) ? 1 : 0);
            chk($sformatf("sat%0d cnt", k), cnt_s, exp_cnt);
            chk($sformatf("sat%0d flag", k), sat_s, (exp_cnt == 3) ? 1 : 0);
            if (k == 10) chk("sat clr fill", fill_s, 0);
            next_cycle();
        end
        clr_s = 1'b0;

        // ---- reset mid-stream after 1,0,1 ----
        for (int i = 0; i < 3; i++) begin
            vld_a = 1'b1;
            bit_a = (i != 1);
            next_cycle();
        end
        vld_a = 1'b0;
        chk("pre-rst fill", fill_d, 3);
        reset = 1'b1;
        #1;
        chk("async rst fill", fill_d, 0);
        chk("async rst state", st_d, 0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld_a = 1'b1;
            bit_a = (i != 1);
            @(negedge clk);
            chk($sformatf("post-rst%0d det", i), det_d, 0);
            chk($sformatf("post-rst%0d fill", i), fill_d, i);
            next_cycle();
        end
        vld_a = 1'b0;
        @(negedge clk);
        chk("post-rst det", det_d, 1);
        chk("post-rst cnt", cnt_d, 1);
        next_cycle();
        @(negedge clk);
        chk("post-rst det drop", det_d, 0);
        next_cycle();

`ifdef SEQDET_PROG_EN
        // ---- runtime pattern load ----
        vld_a = 1'b1;
        bit_a = 1'b1;
        pl_a  = 1'b1;
        pd_a  = 4'b0110;
        next_cycle();
        pl_a = 1'b0;
        @(negedge clk);
        chk("load fill", fill_d, 0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] p;
            p = 4'b0110;
            bit_a = p[3-i];
            @(negedge clk);
            chk($sformatf("prog%0d det", i), det_d, 0);
            next_cycle();
        end
        vld_a = 1'b0;
        @(negedge clk);
        chk("prog det", det_d, 1);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] p;
            p = 4'b1011;
            vld_a = (i < 4);
            bit_a = (i < 4) ? p[3-i] : 1'b0;
            @(negedge clk);
            chk($sformatf("old%0d det", i), det_d, 0);
            next_cycle();
        end
        vld_a = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
